// File: rtl/sd_dat_tx.sv
// sd_dat_tx: SD 4-bit DAT block writer. Sends start bit, data nibbles, per-line CRC16 and end bit,
// then reads the card's CRC status token and waits out busy. All SD-side steps advance on i_sd_clk_strobe.
module sd_dat_tx #(
  parameter int BLOCK_WORDS = 128
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_clk_strobe,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_pop,
  output logic        o_sd_dat_oe,
  output logic [3:0]  o_sd_dat,
  input  logic [3:0]  i_sd_dat,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_error,
  output logic        o_underrun,
  output logic        o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_CRC, S_END, S_STATUS, S_BUSY
  } state_t;

  localparam logic [7:0] LAST_WORD = 8'(BLOCK_WORDS - 1);
  localparam logic [2:0] TOKEN_OK  = 3'b010;

  state_t           state;
  logic [31:0]      shreg;
  logic [3:0][15:0] crc, crc_fed, crc_shl;
  logic [3:0]       crc_feed, crc_msbs;
  logic [7:0]       word_cnt;
  logic [2:0]       nib_cnt;
  logic [2:0]       token;
  logic [5:0]       cnt;
  logic             start_sent;
  logic             got_start;
  logic             dat0;
  logic             unused_dat;

  assign dat0       = i_sd_dat[0];
  assign unused_dat = ^i_sd_dat[3:1];
  assign o_busy     = (state != S_IDLE);

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // The nibble about to be driven: next nibble of the current word, or the FIFO head on a load.
  always_comb begin
    crc_feed = (state == S_DATA && nib_cnt != 3'd7) ? shreg[27:24] : i_fifo_data[31:28];
    for (int k = 0; k < 4; k++) begin
      crc_fed[k]  = crc16_step(crc[k], crc_feed[k]);
      crc_shl[k]  = {crc[k][14:0], 1'b0};
      crc_msbs[k] = crc[k][15];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      crc         <= '0;
      word_cnt    <= '0;
      nib_cnt     <= '0;
      token       <= '0;
      cnt         <= '0;
      start_sent  <= 1'b0;
      got_start   <= 1'b0;
      o_fifo_pop  <= 1'b0;
      o_sd_dat_oe <= 1'b0;
      o_sd_dat    <= 4'hF;
      o_done      <= 1'b0;
      o_crc_error <= 1'b0;
      o_underrun  <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so any branch below raises them for exactly one clock.
      o_fifo_pop <= 1'b0;
      o_done     <= 1'b0;
      if (state == S_IDLE) begin
        if (i_start) begin
          state       <= S_START;
          crc         <= '0;
          word_cnt    <= '0;
          nib_cnt     <= '0;
          token       <= '0;
          cnt         <= '0;
          start_sent  <= 1'b0;
          got_start   <= 1'b0;
          o_crc_error <= 1'b0;
          o_underrun  <= 1'b0;
          o_timeout   <= 1'b0;
        end
      end else if (i_abort) begin
        state       <= S_IDLE;
        o_sd_dat_oe <= 1'b0;
        o_sd_dat    <= 4'hF;
        o_done      <= 1'b1;
      end else if (i_sd_clk_strobe) begin
        case (state)
          S_START, S_DATA: begin
            if (state == S_START && !start_sent) begin
              start_sent  <= 1'b1;
              o_sd_dat_oe <= 1'b1;
              o_sd_dat    <= 4'h0;
            end else if (state == S_DATA && nib_cnt != 3'd7) begin
              shreg    <= {shreg[27:0], 4'h0};
              o_sd_dat <= shreg[27:24];
              crc      <= crc_fed;
              nib_cnt  <= nib_cnt + 3'd1;
            end else if (state == S_DATA && word_cnt == LAST_WORD) begin
              state    <= S_CRC;
              o_sd_dat <= crc_msbs;
              crc      <= crc_shl;
              cnt      <= '0;
            end else if (i_fifo_empty) begin
              state       <= S_IDLE;
              o_sd_dat_oe <= 1'b0;
              o_sd_dat    <= 4'hF;
              o_underrun  <= 1'b1;
              o_done      <= 1'b1;
            end else begin
              state      <= S_DATA;
              shreg      <= i_fifo_data;
              o_sd_dat   <= i_fifo_data[31:28];
              crc        <= crc_fed;
              o_fifo_pop <= 1'b1;
              nib_cnt    <= '0;
              if (state == S_DATA) word_cnt <= word_cnt + 8'd1;
            end
          end
          S_CRC: begin
            if (cnt == 6'd15) begin
              state    <= S_END;
              o_sd_dat <= 4'hF;
            end else begin
              o_sd_dat <= crc_msbs;
              crc      <= crc_shl;
              cnt      <= cnt + 6'd1;
            end
          end
          S_END: begin
            state       <= S_STATUS;
            o_sd_dat_oe <= 1'b0;
            o_sd_dat    <= 4'hF;
            cnt         <= '0;
            got_start   <= 1'b0;
          end
          S_STATUS: begin
            if (!got_start) begin
              if (!dat0) begin
                got_start <= 1'b1;
                cnt       <= '0;
              end else if (cnt == 6'd63) begin
                state     <= S_IDLE;
                o_timeout <= 1'b1;
                o_done    <= 1'b1;
              end else begin
                cnt <= cnt + 6'd1;
              end
            end else if (cnt != 6'd3) begin
              token <= {token[1:0], dat0};
              cnt   <= cnt + 6'd1;
            end else begin
              if (token != TOKEN_OK || !dat0) o_crc_error <= 1'b1;
              state <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (dat0) begin
              state  <= S_IDLE;
              o_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/sd_dat_tx.md
SD_DAT_TX -- requirements
Module: sd_dat_tx

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 128: number of 32-bit words per block (1..256).
REQ-002 SHALL have port i_clk, input, 1: sole clock.
REQ-003 SHALL have port i_reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_sd_clk_strobe, input, 1: one-cycle pulse marking each SD clock falling edge; the sole advance point for all SD-side activity.
REQ-005 SHALL have port i_start, input, 1: begin block transfer; accepted only in IDLE.
REQ-006 SHALL have port i_abort, input, 1: terminate any transfer.
REQ-007 SHALL have port i_fifo_empty, input, 1: source FIFO empty.
REQ-008 SHALL have port i_fifo_data, input, 32: source FIFO head word.
REQ-009 SHALL have port o_fifo_pop, output, 1: one-cycle pop of the FIFO head.
REQ-010 SHALL have port o_sd_dat_oe, output, 1: DAT[3:0] output enable.
REQ-011 SHALL have port o_sd_dat, output, 4: DAT[3:0] drive value.
REQ-012 SHALL have port i_sd_dat, input, 4: DAT[3:0] sampled value (only bit 0 used).
REQ-013 SHALL have port o_busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse on return to IDLE from any terminating event.
REQ-015 SHALL have port o_crc_error, o_underrun and o_timeout, outputs, 1 each: sticky status, cleared on accepted i_start.

Function
REQ-016 SHALL implement states IDLE, START, DATA, CRC, END, STATUS, BUSY; transitions occur only on cycles with i_sd_clk_strobe=1, except IDLE exit and abort.
REQ-017 SHALL, on i_start in IDLE, enter START the same cycle, clear status, CRC registers and counters.
REQ-018 SHALL, on the first strobe in START, drive o_sd_dat_oe=1, o_sd_dat=4'b0000 (start bit).
REQ-019 SHALL, on the next strobe (START->DATA), load the shift register from i_fifo_data and pulse o_fifo_pop for exactly that cycle; o_sd_dat becomes bits [31:28].
REQ-020 SHALL, on each DATA strobe, shift left 4 (order [31:28],[27:24],...,[3:0]); after nibble [3:0], load the next word with a pop, until BLOCK_WORDS words are sent.
REQ-021 SHALL, if i_fifo_empty=1 at any load point, not pop, set o_underrun, deassert o_sd_dat_oe and return to IDLE with o_done.
REQ-022 SHALL maintain four independent CRC16 (x^16+x^12+x^5+1, init 0x0000) registers, DAT line n fed with each data bit as it is driven on line n.
REQ-023 SHALL, after the last data nibble, enter CRC and drive 16 nibbles, bit k of nibble i = bit (15-i) of CRC line k (MSB first).
REQ-024 SHALL then drive END 4'b1111 for one strobe, then deassert o_sd_dat_oe on the following strobe and enter STATUS.
REQ-025 SHALL, in STATUS, sample i_sd_dat[0] each strobe: wait for 0 (start bit), capture 3 token bits, then expect 1 (end bit).
REQ-026 SHALL set o_crc_error if token != 3'b010 or the end bit is 0, then proceed to BUSY regardless.
REQ-027 SHALL set o_timeout and return to IDLE if no start bit within 64 strobes of entering STATUS.
REQ-028 SHALL, in BUSY, remain while sampled i_sd_dat[0]=0; on first sampled 1 return to IDLE and pulse o_done.
REQ-029 SHALL, on i_abort in any non-IDLE state, return to IDLE next cycle, deassert o_sd_dat_oe, not pop, pulse o_done; status flags unchanged.
REQ-030 SHALL ignore i_start while not IDLE; i_abort takes priority over strobe in the same cycle.
REQ-031 SHALL drive exactly BLOCK_WORDS pops per successful block; total driven strobes = 1 + 8*BLOCK_WORDS + 16 + 1 (1042 at default).

Reset
REQ-032 SHALL, on i_reset asserted, asynchronously set state IDLE, o_sd_dat_oe=0, o_sd_dat=4'b1111, o_fifo_pop=0, o_busy=0, o_done=0, all status flags 0, CRCs 0, counters 0.
REQ-033 SHALL, if reset is asserted mid-transfer, perform no further pops and release DAT lines immediately.

Verification
REQ-034 SHALL cover: FIFO preloaded 128 x 32'h00000000, start, card token 010 then 2 busy strobes -> 1042 driven strobes, 128 pops, CRC nibbles all 0000, o_done, no flags.
REQ-035 SHALL cover: 128 x 32'h12345678 -> nibble stream 1,2,...,8 per word; CRC per line equal to bit-serial model; o_done, no flags.
REQ-036 SHALL cover: card returns token 101 -> o_crc_error=1 after STATUS, o_done after busy release.
REQ-037 SHALL cover: FIFO empties after 10 words -> 10 pops, o_underrun=1, oe=0, o_done.
REQ-038 SHALL cover: DAT0 held 1 after END -> o_timeout=1 on 64th STATUS strobe; i_abort during DATA -> IDLE next cycle, oe=0.
REQ-039 SHALL cover: i_reset asserted asynchronously mid-DATA -> outputs at reset values before next clock edge, no pop.
